dbg_abstract_cmd: RTL
=====================

Name: dbg_abstract_cmd

Overview:
Sequencer that executes RISC-V debug "Access Register" abstract commands on behalf of the debug module. It owns the abstractcs busy/cmderr state and latches the command register. It drives the register-file debug port to move data between data0 and the GPRs. It sits between the DMI register decode and the hart register-file debug port.

Parameters:
REGNO_BASE, 16'h1000, regno of x0; GPRs occupy REGNO_BASE to REGNO_BASE+NREGS-1
NREGS, 32, number of accessible GPRs (power of two)

Ports:
iClk  in  1  clock
iRst  in  1  synchronous active-high reset
iCmdWr  in  1  one-cycle pulse: DMI write to command register
iCommand  in  32  DMI write data for command
oCommand  out  32  latched command (regno reflects post-increment)
iHalted  in  1  hart is halted
iCmdErrClr  in  3  W1C mask from DMI write to abstractcs.cmderr (one cycle)
oBusy  out  1  abstractcs.busy
oCmdErr  out  3  abstractcs.cmderr
iData0  in  32  current data0 value
oData0  out  32  data to load into data0
oData0We  out  1  data0 load strobe (one cycle)
oRegAddr  out  5  GPR index
oRegRe  out  1  GPR read strobe; iRegRData is valid on the next cycle
iRegRData  in  32  GPR read data
oRegWe  out  1  GPR write strobe
oRegWData  out  32  GPR write data

Behaviour:
- Reset (iRst high at an edge) has priority over everything else. After reset: state IDLE; oCommand=0, oBusy=0, oCmdErr=0, oData0=0, oData0We=0, oRegAddr=0, oRegRe=0, oRegWe=0, oRegWData=0. Reset mid-command abandons the command; no further strobes are issued.
- Command field decode: cmdtype=[31:24], aarsize=[22:20], postincrement=[19], postexec=[18], transfer=[17], write=[16], regno=[15:0].
- States: IDLE, DECODE, READ, CAPTURE, WRITE, DONE. oBusy=1 in every state except IDLE. Strobes are registered-state decodes: each is high for exactly one cycle.
- IDLE: on iCmdWr with oCmdErr==0, latch iCommand into oCommand and go to DECODE. iCmdWr while oCmdErr!=0 is ignored; the command is not latched.
- iCmdWr while busy: the command is ignored, cmderr is set to 1 (busy), and execution continues.
- DECODE checks errors in priority order and sets the first that applies, then goes to DONE:
  - cmdtype!=0 → 2
  - aarsize!=2 with transfer=1 → 2
  - postexec=1 → 2
  - transfer=1 with regno outside the GPR range → 3 (exception)
  - iHalted=0 → 4
- DECODE with no error: transfer=0 → DONE; write=1 → WRITE; otherwise → READ.
- READ: oRegRe=1, oRegAddr=regno[4:0] → CAPTURE.
- CAPTURE: oData0=iRegRData, oData0We=1 → DONE.
- WRITE: oRegWe=1, oRegAddr=regno[4:0], oRegWData=iData0 → DONE.
- DONE: if postincrement=1 and no error was set in DECODE, oCommand[15:0] <= regno+1 (16-bit wrap, out-of-range result permitted). Then → IDLE.
- Busy length from the cycle after the iCmdWr pulse: read 4 cycles, write 3 cycles, transfer=0 or error 2 cycles.
- iHalted is sampled only in DECODE; deassertion later does not abort the command.
- cmderr update each cycle: oCmdErr <= (oCmdErr & ~iCmdErrClr), then any new error is ORed in. A new error set in the same cycle as a clear wins. cmderr holds only the first error: a new code is written only when oCmdErr==0 after the clear.
- x0 semantics are owned by the register file; this block does not special-case regno 0x1000.

Test Plan:
- Halted; iData0=0xDEADBEEF; command 0x00231005 (write x5, size 2) → one oRegWe cycle with addr 5 and data 0xDEADBEEF; oBusy high 3 cycles; oCmdErr=0.
- Halted; command 0x00221005 (read x5); iRegRData=0x12345678 on the cycle after oRegRe → oData0We for one cycle with oData0=0x12345678; oBusy high 4 cycles.
- Not halted; read command → no strobes, oCmdErr=4. Further iCmdWr is ignored until iCmdErrClr=3'b111, after which a command executes normally.
- Command 0x002A101F (read x31, postincrement) → read of addr 31, then oCommand[15:0]=0x1020. Re-issuing oCommand → oCmdErr=3, no strobes.
- Error cases: cmdtype=1 → 2; aarsize=3 → 2; iCmdWr during a read busy period → oCmdErr=1 and the original read still completes with a data0 write.
- iRst asserted in READ → next cycle all outputs 0, no CAPTURE strobe; a new command then executes normally.

Source files
------------

// File: rtl/dbg_abstract_cmd.sv
// dbg_abstract_cmd: executes RISC-V debug Access Register abstract commands against the GPR debug port.
module dbg_abstract_cmd #(
    parameter logic [15:0] REGNO_BASE = 16'h1000,
    parameter int          NREGS      = 32
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iCmdWr,
    input  logic [31:0] iCommand,
    output logic [31:0] oCommand,
    input  logic        iHalted,
    input  logic [2:0]  iCmdErrClr,
    output logic        oBusy,
    output logic [2:0]  oCmdErr,
    input  logic [31:0] iData0,
    output logic [31:0] oData0,
    output logic        oData0We,
    output logic [4:0]  oRegAddr,
    output logic        oRegRe,
    input  logic [31:0] iRegRData,
    output logic        oRegWe,
    output logic [31:0] oRegWData
);
    typedef enum logic [2:0] {IDLE, DECODE, READ, CAPTURE, WRITE, DONE} state_t;
    state_t      r_state, w_next;
    logic        r_err;
    logic [15:0] w_off;
    logic [2:0]  w_dec_err, w_new_err, w_kept;
    logic        w_accept;
    always_comb begin
        w_off     = oCommand[15:0] - REGNO_BASE;
        w_dec_err = (oCommand[31:24] != 8'd0)                    ? 3'd2 :
                    (oCommand[17] && oCommand[22:20] != 3'd2)    ? 3'd2 :
                    oCommand[18]                                 ? 3'd2 :
                    (oCommand[17] && w_off >= 16'(NREGS))        ? 3'd3 :
                    !iHalted                                     ? 3'd4 : 3'd0;
        w_accept  = r_state == IDLE && iCmdWr && oCmdErr == 3'd0;
        // A decode error outranks a simultaneous busy-write error
        w_new_err = (r_state == DECODE && w_dec_err != 3'd0) ? w_dec_err :
                    (r_state != IDLE && iCmdWr)             ? 3'd1 : 3'd0;
        w_kept    = oCmdErr & ~iCmdErrClr;
        w_next    = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? DECODE : IDLE;
            DECODE:  w_next = (w_dec_err != 3'd0 || !oCommand[17]) ? DONE :
                              oCommand[16] ? WRITE : READ;
            READ:    w_next = CAPTURE;
            CAPTURE: w_next = DONE;
            WRITE:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= IDLE;
            r_err    <= 1'b0;
            oCommand <= '0;
            oCmdErr  <= '0;
        end else begin
            r_state <= w_next;
            oCmdErr <= (w_kept == 3'd0 && w_new_err != 3'd0) ? w_new_err : w_kept;
            if (w_accept)
                oCommand <= iCommand;
            if (r_state == DECODE)
                r_err <= w_dec_err != 3'd0;
            if (r_state == DONE && oCommand[19] && !r_err)
                oCommand[15:0] <= oCommand[15:0] + 16'd1;
        end
    end
    assign oBusy     = r_state != IDLE;
    assign oRegRe    = r_state == READ;
    assign oRegWe    = r_state == WRITE;
    assign oData0We  = r_state == CAPTURE;
    assign oRegAddr  = (oRegRe || oRegWe) ? oCommand[4:0] : 5'd0;
    assign oRegWData = oRegWe ? iData0 : 32'd0;
    assign oData0    = oData0We ? iRegRData : 32'd0;
endmodule
